// File: rtl/memaccess_ctrl_if.sv
// Request and data-memory bus bundle for memaccess_ctrl.
// addr_err exists only when MEMACCESS_ADDR_CHK_EN is defined.
interface memaccess_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_mode;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;

    logic [AW-1:0] DMem_addr;
    logic [DW-1:0] Dmem_din;
    logic          DMem_rd;
    logic          DMem_en;
    logic [DW-1:0] DMem_dout;
    logic          DMem_ack;

    logic [DW-1:0] memout;
    logic          memout_valid;
    logic          err_timeout;
`ifdef MEMACCESS_ADDR_CHK_EN
    logic          addr_err;
`endif

    // The controller masters the memory strobe and serves requests.
    modport master (
        input  req_valid, req_mode, req_addr, req_data, DMem_dout, DMem_ack,
        output req_ready, DMem_addr, Dmem_din, DMem_rd, DMem_en, memout, memout_valid,
`ifdef MEMACCESS_ADDR_CHK_EN
               addr_err,
`endif
               err_timeout
    );

    modport slave (
        output req_valid, req_mode, req_addr, req_data, DMem_dout, DMem_ack,
        input  req_ready, DMem_addr, Dmem_din, DMem_rd, DMem_en, memout, memout_valid,
`ifdef MEMACCESS_ADDR_CHK_EN
               addr_err,
`endif
               err_timeout
    );
endinterface

// File: rtl/memaccess_ctrl.sv
// LC3 data-memory access controller: direct and indirect loads/stores over a strobe/ack port.
// Define MEMACCESS_ADDR_CHK_EN to reject addresses outside [ADDR_LO, ADDR_HI].
module memaccess_ctrl #(
    parameter int          DW      = 16,
    parameter int          AW      = 16,
    parameter int          TIMEOUT = 15,
    parameter int unsigned ADDR_LO = 'h3000,
    parameter int unsigned ADDR_HI = 'hFDFF
) (
    input  logic             clock,
    input  logic             reset,
    memaccess_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, PTR, ACC, RESP} state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state, state_next;
    logic          wr_q, wr_next;
    logic [CW-1:0] wait_cnt, wait_next;
    logic [AW-1:0] addr_q, addr_next;
    logic [DW-1:0] din_q, din_next;
    logic [DW-1:0] memout_q, memout_next;
    logic          en_q, en_next;
    logic          rd_q, rd_next;
    logic          valid_q, valid_next;
    logic          tmo_q, tmo_next;
    logic          req_ready;
    logic          timed_out;

`ifdef MEMACCESS_ADDR_CHK_EN
    logic aerr_q, aerr_next;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a >= AW'(ADDR_LO)) && (a <= AW'(ADDR_HI));
    endfunction

    assign bus.addr_err = aerr_q;
`else
    logic unused_addr_window;
    assign unused_addr_window = ^{AW'(ADDR_LO), AW'(ADDR_HI)};
`endif

    assign req_ready        = (state == IDLE) && !reset;
    assign bus.req_ready    = req_ready;
    assign bus.DMem_addr    = addr_q;
    assign bus.Dmem_din     = din_q;
    assign bus.DMem_rd      = rd_q;
    assign bus.DMem_en      = en_q;
    assign bus.memout       = memout_q;
    assign bus.memout_valid = valid_q;
    assign bus.err_timeout  = tmo_q;

    // An ack arriving on the last allowed cycle takes priority over the timeout.
    assign timed_out = (TIMEOUT != 0) && !bus.DMem_ack && (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_next  = state;
        wr_next     = wr_q;
        wait_next   = wait_cnt;
        addr_next   = addr_q;
        din_next    = din_q;
        memout_next = memout_q;
        en_next     = en_q;
        rd_next     = rd_q;
        valid_next  = 1'b0;
        tmo_next    = 1'b0;
`ifdef MEMACCESS_ADDR_CHK_EN
        aerr_next   = 1'b0;
`endif
        if (en_q && !bus.DMem_ack) begin
            wait_next = wait_cnt + CW'(1);
        end

        unique case (state)
            IDLE: begin
                if (bus.req_valid && req_ready) begin
                    wr_next    = bus.req_mode[0];
                    addr_next  = bus.req_addr;
                    din_next   = bus.req_data;
                    wait_next  = '0;
                    en_next    = 1'b1;
                    rd_next    = bus.req_mode[1] | ~bus.req_mode[0];
                    state_next = bus.req_mode[1] ? PTR : ACC;
`ifdef MEMACCESS_ADDR_CHK_EN
                    if (!addr_ok(bus.req_addr)) begin
                        en_next    = 1'b0;
                        rd_next    = 1'b1;
                        aerr_next  = 1'b1;
                        state_next = IDLE;
                    end
`endif
                end
            end
            PTR: begin
                // The strobe stays up while the address switches to the pointer target.
                if (bus.DMem_ack) begin
                    addr_next  = bus.DMem_dout[AW-1:0];
                    rd_next    = ~wr_q;
                    wait_next  = '0;
                    state_next = ACC;
`ifdef MEMACCESS_ADDR_CHK_EN
                    if (!addr_ok(bus.DMem_dout[AW-1:0])) begin
                        en_next    = 1'b0;
                        rd_next    = 1'b1;
                        aerr_next  = 1'b1;
                        state_next = IDLE;
                    end
`endif
                end else if (timed_out) begin
                    en_next    = 1'b0;
                    tmo_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            ACC: begin
                if (bus.DMem_ack) begin
                    en_next    = 1'b0;
                    state_next = RESP;
                    if (!wr_q) begin
                        memout_next = bus.DMem_dout;
                        valid_next  = 1'b1;
                    end
                end else if (timed_out) begin
                    en_next    = 1'b0;
                    tmo_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            wait_cnt <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            memout_q <= '0;
            en_q     <= 1'b0;
            rd_q     <= 1'b1;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
`ifdef MEMACCESS_ADDR_CHK_EN
            aerr_q   <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            wr_q     <= wr_next;
            wait_cnt <= wait_next;
            addr_q   <= addr_next;
            din_q    <= din_next;
            memout_q <= memout_next;
            en_q     <= en_next;
            rd_q     <= rd_next;
            valid_q  <= valid_next;
            tmo_q    <= tmo_next;
`ifdef MEMACCESS_ADDR_CHK_EN
            aerr_q   <= aerr_next;
`endif
        end
    end
endmodule
